fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. Clock and reset SHALL use the codebase port names Clk and Clr.
REQ-002 Parameter ADDR_W, 8, PC and instruction-memory address width.
REQ-003 Parameter INSTR_W, 32, instruction width.
REQ-004 Parameter DEPTH, 4, queue entries; power of two, at least 2.
REQ-005 Parameter PC_STEP, 4, PC increment per fetch.
REQ-006 Parameter RESET_PC, 0, PC value after reset.
REQ-007 Clk  in  1  rising-edge clock.
REQ-008 Clr  in  1  synchronous active-low reset.
REQ-009 imem_addr  out  ADDR_W  fetch address to a combinational instruction ROM; always equals the PC register.
REQ-010 imem_data  in  INSTR_W  ROM data for imem_addr, valid in the same cycle.
REQ-011 redirect  in  1  branch/BL taken; flushes the queue.
REQ-012 redirect_pc  in  ADDR_W  target PC, sampled when redirect=1.
REQ-013 out_valid  out  1  queue head holds a valid instruction.
REQ-014 out_ready  in  1  IF/ID stage accepts the head (IF/ID LE).
REQ-015 out_instr  out  INSTR_W  head instruction; all zeros (NOP) when out_valid=0.
REQ-016 out_next_pc  out  ADDR_W  fetch PC of the head plus PC_STEP; zero when out_valid=0.
REQ-017 count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 pop SHALL be defined as out_valid AND out_ready AND NOT redirect.
REQ-019 push SHALL be defined as NOT redirect AND (count<DEPTH OR pop).
- A full queue accepts a push in the same cycle as a pop.
REQ-020 On push, the block SHALL write {imem_data, imem_addr+PC_STEP} at the tail and update PC to PC+PC_STEP at the clock edge.
REQ-021 With neither push nor redirect, PC SHALL hold.
REQ-022 PC arithmetic SHALL wrap modulo 2^ADDR_W: 8'hFC + 4 = 8'h00.
REQ-023 On pop, the head SHALL advance one entry at the clock edge.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-025 count SHALL change by push minus pop: +1, 0 or -1.
REQ-026 Outputs SHALL be driven combinationally from the head entry.
REQ-027 Latency: an instruction fetched in cycle N SHALL be visible on out_instr in cycle N+1 if the queue was empty.
REQ-028 On redirect=1 at a clock edge:
- count becomes 0 and the pointers reset;
- PC becomes redirect_pc;
- no push or pop takes effect.
REQ-029 Redirect SHALL override out_ready and any simultaneous push or pop.
REQ-030 Behaviour at full:
- full with no pop: no push and PC holds (fetch stall);
- imem_addr stays stable until space frees.
REQ-031 At empty: out_valid=0, out_instr=0 and out_next_pc=0; out_ready is ignored.
REQ-032 Back-to-back redirects SHALL each reload PC; the queue stays empty while redirect=1.

Reset
REQ-033 When Clr=0 at a clock edge:
- PC=RESET_PC and count=0;
- pointers=0;
- out_valid=0, out_instr=0, out_next_pc=0.
REQ-034 Reset SHALL take priority over redirect, push and pop, including in mid-operation with a full queue.
REQ-035 Queue storage contents SHALL need no reset; validity comes only from count.

Structure
REQ-036 NOP_INSTR (all zeros) and the default PC_STEP SHALL be defined in a shared package, pipeline_pkg, for reuse by the CU mux and the pipeline registers.
REQ-037 Storage and pointers SHALL be a sub-module, instr_fifo, parametrised by width and DEPTH, with its flush driven by redirect.
REQ-038 The PC register and the push/pop logic SHALL reside in fetch_queue.

Verification
REQ-039 Reset release, ROM[0]=32'hE2811001, out_ready=1 -> cycle 1: out_valid=1, out_instr=E2811001, out_next_pc=4; sequential PCs follow 0, 4, 8.
REQ-040 out_ready=0 for 6 cycles, DEPTH=4 -> count reaches 4; imem_addr freezes at 16; entries hold PCs 0, 4, 8, 12 in order.
REQ-041 Full queue, out_ready=1 -> push and pop in the same cycle; count stays 4; PC advances by 4 each cycle.
REQ-042 redirect=1, redirect_pc=8'h40 while count=3 -> next cycle count=0, out_valid=0, out_instr=0, imem_addr=8'h40; first instruction from 8'h40 appears one cycle later.
REQ-043 redirect=1 together with out_ready=1 and a non-full queue -> no pop or push is observed; with RESET_PC=8'hFC, fetch wraps to 8'h00.
REQ-044 Clr=0 asserted with a full queue and redirect=1 -> next edge: count=0, imem_addr=RESET_PC, all outputs zero.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants shared by the fetch queue, CU mux and pipeline registers
package pipeline_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int PC_STEP_DEFAULT = 4;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: circular entry store with head/tail pointers, occupancy count and flush
module instr_fifo #(
    parameter int W = 40,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    assign rdata = mem[head];

    // storage carries no reset; validity is tracked only by count
    always_ff @(posedge Clk) begin
        if (push) mem[tail] <= wdata;
    end

    // pointers wrap naturally at DEPTH; flush empties the queue like reset
    always_ff @(posedge Clk) begin
        if (!Clr || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC register plus instruction prefetch queue feeding the IF/ID stage
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH = 4,
    parameter int PC_STEP = PC_STEP_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Clr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_next_pc,
    output logic [CW-1:0]      count
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]         pc;
    logic                      push;
    logic                      pop;
    logic [INSTR_W+ADDR_W-1:0] head;

    assign imem_addr = pc;

    // redirect blocks both ends; a full queue still takes a push when it pops
    always_comb begin
        out_valid   = count != '0;
        pop         = out_valid && out_ready && !redirect;
        push        = !redirect && (count < CW'(DEPTH) || pop);
        out_instr   = out_valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : INSTR_W'(NOP_INSTR);
        out_next_pc = out_valid ? head[ADDR_W-1:0] : '0;
    end

    // PC reloads on redirect, advances on each accepted fetch, else holds
    always_ff @(posedge Clk) begin
        if (!Clr) pc <= RESET_PC;
        else if (redirect) pc <= redirect_pc;
        else if (push) pc <= pc + STEP;
    end

    instr_fifo #(.W(INSTR_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .Clk   (Clk),
        .Clr   (Clr),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({imem_data, pc + STEP}),
        .rdata (head),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a bench-side ROM
module tb_fetch_queue;
    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        out_ready = 1'b1;
    logic [7:0]  imem_addr, w_addr;
    logic [31:0] imem_data, w_data;
    logic        out_valid, w_valid;
    logic [31:0] out_instr, w_instr;
    logic [7:0]  out_next_pc, w_next_pc;
    logic [2:0]  count, w_count;
    int          total = 0;
    int          passed = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return 32'hE281_1001 ^ {24'h0, a};
    endfunction

    assign imem_data = rom(imem_addr);
    assign w_data    = rom(w_addr);

    fetch_queue u_dut (
        .Clk(Clk), .Clr(Clr), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_next_pc(out_next_pc),
        .count(count)
    );

    fetch_queue #(.RESET_PC(8'hFC)) u_wrap (
        .Clk(Clk), .Clr(Clr), .imem_addr(w_addr), .imem_data(w_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(w_valid),
        .out_ready(out_ready), .out_instr(w_instr), .out_next_pc(w_next_pc),
        .count(w_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    // all stimulus changes and samples happen on the falling edge
    initial begin
        step(2);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_instr", out_instr, 0);
        check("rst_npc", 32'(out_next_pc), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wrap_addr", 32'(w_addr), 32'hFC);
        Clr = 1'b1;
        step();
        check("c1_valid", 32'(out_valid), 1);
        check("c1_instr", out_instr, 32'hE281_1001);
        check("c1_npc", 32'(out_next_pc), 4);
        check("c1_addr", 32'(imem_addr), 4);
        check("wrap_addr", 32'(w_addr), 0);
        check("wrap_npc", 32'(w_next_pc), 0);
        check("wrap_instr", w_instr, 32'hE281_10FD);
        step();
        check("c2_instr", out_instr, 32'hE281_1005);
        check("c2_npc", 32'(out_next_pc), 8);
        check("c2_count", 32'(count), 1);
        step();
        check("c3_npc", 32'(out_next_pc), 12);
        check("c3_addr", 32'(imem_addr), 12);
        redirect = 1'b1;
        redirect_pc = 8'h00;
        step();
        redirect = 1'b0;
        out_ready = 1'b0;
        step(6);
        check("fill_count", 32'(count), 4);
        check("fill_addr", 32'(imem_addr), 16);
        check("fill_head_npc", 32'(out_next_pc), 4);
        check("fill_head_instr", out_instr, 32'hE281_1001);
        out_ready = 1'b1;
        step();
        check("full_count1", 32'(count), 4);
        check("full_npc1", 32'(out_next_pc), 8);
        check("full_addr1", 32'(imem_addr), 20);
        step();
        check("full_npc2", 32'(out_next_pc), 12);
        check("full_instr2", out_instr, 32'hE281_1009);
        check("full_addr2", 32'(imem_addr), 24);
        step();
        check("full_npc3", 32'(out_next_pc), 16);
        check("full_count3", 32'(count), 4);
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        out_ready = 1'b0;
        step(3);
        check("three_count", 32'(count), 3);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        out_ready = 1'b1;
        step();
        check("rd_count", 32'(count), 0);
        check("rd_valid", 32'(out_valid), 0);
        check("rd_instr", out_instr, 0);
        check("rd_npc", 32'(out_next_pc), 0);
        check("rd_addr", 32'(imem_addr), 32'h40);
        redirect_pc = 8'h60;
        step();
        check("rd2_addr", 32'(imem_addr), 32'h60);
        check("rd2_count", 32'(count), 0);
        redirect = 1'b0;
        step();
        check("after_rd_valid", 32'(out_valid), 1);
        check("after_rd_instr", out_instr, 32'hE281_1061);
        check("after_rd_npc", 32'(out_next_pc), 32'h64);
        redirect = 1'b1;
        redirect_pc = 8'h20;
        step();
        check("rd_pop_count", 32'(count), 0);
        check("rd_pop_addr", 32'(imem_addr), 32'h20);
        redirect_pc = 8'h00;
        step();
        redirect = 1'b0;
        out_ready = 1'b0;
        step(4);
        check("refill_count", 32'(count), 4);
        Clr = 1'b0;
        redirect = 1'b1;
        redirect_pc = 8'h40;
        step();
        check("clr_count", 32'(count), 0);
        check("clr_addr", 32'(imem_addr), 0);
        check("clr_valid", 32'(out_valid), 0);
        check("clr_instr", out_instr, 0);
        check("clr_npc", 32'(out_next_pc), 0);
        check("clr_wrap_addr", 32'(w_addr), 32'hFC);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
